// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: op bit positions, FSM states,
// and the iteration-count helper.
package div_pkg;

    // Bit positions inside the 2-bit op field.
    localparam int DIV_OP_SIGNED = 0;
    localparam int DIV_OP_REM    = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

    // Number of CALC cycles needed to produce all quotient bits.
    function automatic int iter_count(input int width, input int bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and keep the trial difference when it does not go negative.
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // The shifted remainder needs one extra bit; that bit doubles as the sign
    // of the trial subtract. rem_in < divisor keeps the kept result in WIDTH bits.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem_in, dividend_bit};
    assign trial   = shifted - {1'b0, divisor};
    assign q_bit   = ~trial[WIDTH];
    assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/iter_div_unit.sv
// Iterative signed/unsigned divider (quotient or remainder) for the EX stage.
// Handshake: a request is taken on a rising edge where in_valid & in_ready
// (in_ready only in IDLE); a result is handed over on a rising edge where
// out_valid & out_ready, and out_valid/out_result stay put until then.
module iter_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam int ITERS = iter_count(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = $clog2(ITERS);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] src1_q, src2_q;
    logic [WIDTH-1:0] quot_q, div_q, rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q_q, sign_r_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] fix_result;
    logic             accept;
    logic             is_signed, neg1, neg2;

    // Step chain: index 0 is the registered state, index BITS_PER_CYCLE the next.
    logic [WIDTH-1:0]          rem_chain  [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0]          quot_chain [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] q_bits;

    assign rem_chain[0]  = rem_q;
    assign quot_chain[0] = quot_q;

    // Quotient register doubles as the dividend shifter: MSB out, new q bit in.
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        div_iter_step #(.WIDTH(WIDTH)) u_step (
            .rem_in       (rem_chain[i]),
            .dividend_bit (quot_chain[i][WIDTH-1]),
            .divisor      (div_q),
            .rem_out      (rem_chain[i+1]),
            .q_bit        (q_bits[i])
        );
        assign quot_chain[i+1] = {quot_chain[i][WIDTH-2:0], q_bits[i]};
    end

    assign accept    = (state_q == ST_IDLE) && in_valid && !flush;
    assign is_signed = op_q[DIV_OP_SIGNED];
    assign neg1      = is_signed && src1_q[WIDTH-1];
    assign neg2      = is_signed && src2_q[WIDTH-1];
    assign out_result = result_q;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state and handshake outputs; flush wins over every other transition.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = ST_PREP;
            end
            ST_PREP: state_d = ST_CALC;
            ST_CALC: if (cnt_q == '0) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Sign correction and special cases; divide-by-zero beats the overflow case.
    always_comb begin
        logic [WIDTH-1:0] q_val, r_val;
        q_val = sign_q_q ? -quot_q : quot_q;
        r_val = sign_r_q ? -rem_q  : rem_q;
        if (src2_q == '0) begin
            q_val = '1;
            r_val = src1_q;
        end else if (is_signed && src1_q == MIN_INT && src2_q == '1) begin
            q_val = MIN_INT;
            r_val = '0;
        end
        fix_result = op_q[DIV_OP_REM] ? r_val : q_val;
    end

    // Operand latching, magnitude prep, iteration and result registration.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            quot_q   <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            result_q <= '0;
        end else if (!flush) begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    op_q   <= in_op;
                    src1_q <= in_src1;
                    src2_q <= in_src2;
                end
                ST_PREP: begin
                    // |MIN_INT| negates to itself, which is 2^(WIDTH-1) read unsigned.
                    quot_q   <= neg1 ? -src1_q : src1_q;
                    div_q    <= neg2 ? -src2_q : src2_q;
                    rem_q    <= '0;
                    cnt_q    <= CNT_W'(ITERS - 1);
                    sign_q_q <= neg1 ^ neg2;
                    sign_r_q <= neg1;
                end
                ST_CALC: begin
                    rem_q  <= rem_chain[BITS_PER_CYCLE];
                    quot_q <= quot_chain[BITS_PER_CYCLE];
                    cnt_q  <= cnt_q - 1'b1;
                end
                ST_FIX: result_q <= fix_result;
                default: ;
            endcase
        end
    end

endmodule
